// File: rtl/wtm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wtm_mul_arbiter
// Purpose  : Round-robin arbiter that shares one 2-stage, enable-advanced
//            8x8 mantissa multiplier among NREQ requesters. Each product
//            returns on one valid/ready port with its requester id and tag.
//            A drain FSM stops new grants and waits for the pipe to empty.
// Options  : WTM_ARB_STATS_EN adds saturating busy/stall cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module wtm_mul_arbiter #(
  parameter  int NREQ = 4,
  parameter  int TAGW = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*8-1:0]    req_a,
  input  logic [NREQ*8-1:0]    req_b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [TAGW-1:0]      resp_tag,
  output logic [15:0]          resp_prod,
  input  logic                 drain_req,
  output logic                 drained,
  output logic                 mul_nRST,
  output logic                 mul_en,
  output logic [7:0]           mul_A,
  output logic [7:0]           mul_B,
  input  logic [15:0]          mul_S,
  input  logic                 mul_done
`ifdef WTM_ARB_STATS_EN
  ,
  output logic [15:0]          stat_busy,
  output logic [15:0]          stat_stall
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic            v1, v2;
  logic [IDW-1:0]  id1, id2, last;
  logic [TAGW-1:0] tag1, tag2;
  logic            advance, grant_en, grant_any, grant;
  logic [IDW-1:0]  winner, cand;
  int              idx;

  logic [7:0]      a_arr   [NREQ];
  logic [7:0]      b_arr   [NREQ];
  logic [TAGW-1:0] tag_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]   = req_a[i*8 +: 8];
    assign b_arr[i]   = req_b[i*8 +: 8];
    assign tag_arr[i] = req_tag[i*TAGW +: TAGW];
  end

  // The whole pipe moves only when the output slot is empty or being consumed.
  assign advance  = ~v2 | resp_ready;
  assign grant_en = advance & (state == ST_RUN) & ~drain_req & ~RST;
  assign grant    = grant_en & grant_any;

  assign mul_nRST   = ~RST;
  assign mul_en     = advance & ~RST;
  assign resp_valid = v2;
  assign resp_id    = id2;
  assign resp_tag   = tag2;
  assign resp_prod  = mul_S;
  assign drained    = (state == ST_DRAINED);

  // Round-robin search starting one past the last winner.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(last) + k) % NREQ;
      cand = IDW'(idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        winner    = cand;
      end
    end
  end

  // Drive the accept strobe and the winner's operands into the multiplier.
  always_comb begin
    req_ready = '0;
    mul_A     = '0;
    mul_B     = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
      mul_A             = a_arr[winner];
      mul_B             = b_arr[winner];
    end
  end

  // Shadow of the multiplier pipe: stage 1 = input regs, stage 2 = S_out.
  always_ff @(posedge clk) begin
    if (RST) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      id1  <= '0;
      id2  <= '0;
      tag1 <= '0;
      tag2 <= '0;
      last <= IDW'(NREQ - 1);
    end else if (advance) begin
      v2   <= v1;
      id2  <= id1;
      tag2 <= tag1;
      v1   <= grant;
      id1  <= grant ? winner : '0;
      tag1 <= grant ? tag_arr[winner] : '0;
      if (grant) begin
        last <= winner;
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= ST_RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Drain FSM next state; dropping drain_req always returns to RUN.
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN: begin
        if (drain_req) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req)       state_nx = ST_RUN;
        else if (!v1 && !v2)  state_nx = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req) state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

`ifdef WTM_ARB_STATS_EN
  // Saturating occupancy and output-stall counters.
  always_ff @(posedge clk) begin
    if (RST) begin
      stat_busy  <= '0;
      stat_stall <= '0;
    end else begin
      if ((v1 | v2) && (stat_busy != 16'hFFFF)) begin
        stat_busy <= stat_busy + 16'd1;
      end
      if ((v2 & ~resp_ready) && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // The multiplier's own done flag must track our stage-2 valid.
  a_done_tracks_v2: assert property (@(posedge clk) disable iff (RST)
    mul_en |=> (mul_done == v2));
`endif

endmodule
`default_nettype wire

// File: tb/tb_wtm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wtm_mul_arbiter
// Purpose  : Self-checking bench for wtm_mul_arbiter with a behavioural
//            multiplier and a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wtm_mul_arbiter;
  localparam int NREQ = 4;
  localparam int TAGW = 4;

  logic        clk = 1'b0;
  logic        RST;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [15:0] req_tag;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_id;
  logic [3:0]  resp_tag;
  logic [15:0] resp_prod;
  logic        drain_req, drained, mul_nRST, mul_en;
  logic [7:0]  mul_A, mul_B;
  logic [15:0] mul_S;
  logic        mul_done;
`ifdef WTM_ARB_STATS_EN
  logic [15:0] stat_busy, stat_stall;
`endif

  always #5 clk = ~clk;

  wtm_mul_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_tag(resp_tag), .resp_prod(resp_prod),
    .drain_req(drain_req), .drained(drained),
    .mul_nRST(mul_nRST), .mul_en(mul_en),
    .mul_A(mul_A), .mul_B(mul_B), .mul_S(mul_S), .mul_done(mul_done)
`ifdef WTM_ARB_STATS_EN
    , .stat_busy(stat_busy), .stat_stall(stat_stall)
`endif
  );

  // Behavioural 2-stage multiplier with async active-low clear.
  logic [7:0] ma1, mb1;
  logic       md1;
  always @(posedge clk or negedge mul_nRST) begin
    if (!mul_nRST) begin
      ma1 <= 8'd0; mb1 <= 8'd0; md1 <= 1'b0; mul_S <= 16'd0; mul_done <= 1'b0;
    end else if (mul_en) begin
      ma1 <= mul_A; mb1 <= mul_B; md1 <= |req_ready;
      mul_S <= ma1 * mb1; mul_done <= md1;
    end
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: in-flight items carry an age; age 2 means at the output.
  typedef struct { int id; int tag; int prod; int age; } item_t;
  item_t q[$];
  int    rr, mode;            // mode: 0 run, 1 draining, 2 drained
  int    m_busy, m_stall;
  bit    outv, adv;
  int    win, c, ea, eb, et;
  logic [3:0] exp_rdy;

  // Compare DUT against model every cycle, then step the model.
  always @(negedge clk) begin
    if (RST) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mul_en", mul_en, 0);
      chk("rst_mul_nRST", mul_nRST, 0);
      q.delete(); rr = NREQ - 1; mode = 0; m_busy = 0; m_stall = 0;
    end else begin
      outv = (q.size() > 0) && (q[0].age == 2);
      adv  = !outv || resp_ready;
      win  = -1;
      if (adv && mode == 0 && !drain_req) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (rr + k) % NREQ;
          if (win < 0 && req_valid[c]) win = c;
        end
      end
      exp_rdy = 4'd0; ea = 0; eb = 0; et = 0;
      if (win >= 0) begin
        exp_rdy[win] = 1'b1;
        ea = int'(req_a[win*8 +: 8]);
        eb = int'(req_b[win*8 +: 8]);
        et = int'(req_tag[win*4 +: 4]);
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("mul_en", mul_en, adv);
      chk("mul_nRST", mul_nRST, 1);
      chk("mul_A", mul_A, ea);
      chk("mul_B", mul_B, eb);
      chk("resp_valid", resp_valid, outv);
      chk("drained", drained, (mode == 2));
      if (outv) begin
        chk("resp_id", resp_id, q[0].id);
        chk("resp_tag", resp_tag, q[0].tag);
        chk("resp_prod", resp_prod, q[0].prod);
      end
`ifdef WTM_ARB_STATS_EN
      chk("stat_busy", stat_busy, m_busy);
      chk("stat_stall", stat_stall, m_stall);
`endif
      if (q.size() > 0 && m_busy < 65535) m_busy++;
      if (outv && !resp_ready && m_stall < 65535) m_stall++;
      case (mode)
        0: if (drain_req) mode = 1;
        1: if (!drain_req) mode = 0; else if (q.size() == 0) mode = 2;
        default: if (!drain_req) mode = 0;
      endcase
      if (adv) begin
        if (outv) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (win >= 0) q.push_back('{win, et, ea * eb, 1});
      end
      if (win >= 0) rr = win;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RST = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0;
    resp_ready = 1'b1; drain_req = 1'b0;
    repeat (3) cyc();
    RST = 1'b0;
    @(negedge clk);
    chk("post_rst_resp_valid", resp_valid, 0);
    chk("post_rst_drained", drained, 0);

    // Single request: 0x80 * 0x80 = 0x4000, two cycles after accept.
    cyc();
    req_valid = 4'b0001; req_a[7:0] = 8'h80; req_b[7:0] = 8'h80; req_tag[3:0] = 4'h5;
    @(negedge clk); chk("single_t0_ready", req_ready, 4'b0001);
    cyc(); req_valid = '0;
    @(negedge clk); chk("single_t1_valid", resp_valid, 0);
    cyc();
    @(negedge clk);
    chk("single_t2_valid", resp_valid, 1);
    chk("single_t2_prod", resp_prod, 16'h4000);
    chk("single_t2_id", resp_id, 0);
    chk("single_t2_tag", resp_tag, 5);

    // All four requesting after reset: grants 0,1,2,3,0,... no bubbles.
    cyc(); RST = 1'b1;
    cyc(); RST = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 1);
      req_b[i*8 +: 8] = 8'(i + 3);
      req_tag[i*4 +: 4] = 4'(i);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_ready", req_ready, 4'b0001 << (k % 4));
      if (k >= 2) begin
        chk("rr_resp_valid", resp_valid, 1);
        chk("rr_resp_id", resp_id, (k - 2) % 4);
        chk("rr_resp_prod", resp_prod, (((k - 2) % 4) + 1) * (((k - 2) % 4) + 3));
      end
      cyc();
    end

    // Backpressure with a full pipe: id 2 held at the output.
    resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ready", req_ready, 0);
      chk("stall_valid", resp_valid, 1);
      chk("stall_id", resp_id, 2);
      chk("stall_tag", resp_tag, 2);
      chk("stall_prod", resp_prod, 15);
      cyc();
    end
    resp_ready = 1'b1; req_valid = '0;
    @(negedge clk); chk("rel0_valid", resp_valid, 1); chk("rel0_id", resp_id, 2);
    cyc();
    @(negedge clk); chk("rel1_valid", resp_valid, 1); chk("rel1_id", resp_id, 3);
    chk("rel1_prod", resp_prod, 24);
    cyc();
    @(negedge clk); chk("rel2_valid", resp_valid, 0);

    // Drain with two in flight, then resume.
    cyc(); req_valid = 4'b0011;
    @(negedge clk); chk("dr_g0", req_ready, 4'b0001);
    cyc();
    @(negedge clk); chk("dr_g1", req_ready, 4'b0010);
    cyc(); drain_req = 1'b1; req_valid = 4'b1111;
    @(negedge clk); chk("dr_d0_ready", req_ready, 0); chk("dr_d0_id", resp_id, 0);
    cyc();
    @(negedge clk); chk("dr_d1_ready", req_ready, 0); chk("dr_d1_id", resp_id, 1);
    cyc();
    @(negedge clk); chk("dr_d2_drained", drained, 0); chk("dr_d2_ready", req_ready, 0);
    cyc();
    @(negedge clk); chk("dr_d3_drained", drained, 1);
    cyc(); drain_req = 1'b0;
    @(negedge clk); chk("dr_d4_drained", drained, 1); chk("dr_d4_ready", req_ready, 0);
    cyc();
    @(negedge clk); chk("dr_d5_drained", drained, 0); chk("dr_d5_ready", req_ready, 4'b0100);

    // Reset with both stages full.
    cyc(); cyc();
    @(negedge clk); chk("mid_full_valid", resp_valid, 1);
    cyc(); RST = 1'b1; req_valid = '0;
    cyc(); RST = 1'b0;
    @(negedge clk); chk("mid_rst_valid", resp_valid, 0); chk("mid_rst_ready", req_ready, 0);
    cyc(); req_valid = 4'b1111;
    @(negedge clk); chk("mid_rst_first", req_ready, 4'b0001);

`ifdef WTM_ARB_STATS_EN
    // Six busy cycles, three of them stalled.
    cyc(); RST = 1'b1; req_valid = '0; resp_ready = 1'b1;
    cyc(); RST = 1'b0; req_valid = 4'b0001;
    cyc(); req_valid = 4'b0010;
    cyc(); req_valid = '0; resp_ready = 1'b0;
    cyc(); cyc();
    cyc(); resp_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("stat_busy_6", stat_busy, 6);
    chk("stat_stall_3", stat_stall, 3);
`endif

    // Randomised traffic with occasional drains and resets.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      RST        = ($urandom_range(0, 399) == 0);
      req_valid  = 4'($urandom);
      req_a      = $urandom;
      req_b      = $urandom;
      req_tag    = 16'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
    end

`ifdef WTM_ARB_STATS_EN
    // Long stall saturates both counters.
    cyc(); RST = 1'b1; drain_req = 1'b0; req_valid = '0;
    cyc(); RST = 1'b0; req_valid = 4'b0001; resp_ready = 1'b0;
    cyc(); req_valid = '0;
    repeat (70000) cyc();
    @(negedge clk);
    chk("stat_stall_sat", stat_stall, 16'hFFFF);
    chk("stat_busy_sat", stat_busy, 16'hFFFF);
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
